// File: rtl/fruit_scheduler.sv
// Falling-object sequencer for the catch game. On each frame tick it sweeps
// all object slots, one slot per cycle, through a single shared update path:
// it advances y, detects catches against the farmer lane, retires misses and
// spawns new objects from a lane LFSR.
// Optional build macro: SPEEDUP_EN (step grows with score_pos, capped at 2*STEP).
module fruit_scheduler #(
  parameter int unsigned N_OBJ     = 4,
  parameter int unsigned STEP      = 4,
  parameter int unsigned SPAWN_GAP = 16,
  parameter int unsigned CATCH_Y   = 320,
  parameter int unsigned Y_MAX     = 480,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  tick,
  input  logic [2:0]            farmer_x,
  output logic [3*N_OBJ-1:0]    obj_x,
  output logic [10*N_OBJ-1:0]   obj_y,
  output logic [N_OBJ-1:0]      obj_active,
  output logic [5:0]            score_pos,
  output logic [5:0]            score_neg,
  output logic                  catch_pulse,
  output logic                  miss_pulse,
  output logic                  busy
);

  localparam int unsigned IdxW = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
  localparam int unsigned CdW  = $clog2(SPAWN_GAP + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_OBJ - 1);

  typedef enum logic [0:0] {StIdle, StSweep} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            pending_q, pending_d;
  logic [CdW-1:0]  cd_q, cd_d, cd_eff;
  logic [7:0]      lfsr_q, lfsr_d;
  logic [2:0]      x_q [N_OBJ];
  logic [2:0]      x_d [N_OBJ];
  logic [9:0]      y_q [N_OBJ];
  logic [9:0]      y_d [N_OBJ];
  logic [N_OBJ-1:0] act_q, act_d;
  logic [5:0]      pos_q, pos_d, neg_q, neg_d;
  logic            catch_q, catch_d, miss_q, miss_d;
  logic [10:0]     step;
  logic [10:0]     y_new;

`ifdef SPEEDUP_EN
  // Step grows by one pixel per eight fruits caught, capped at twice the base step.
  always_comb begin
    step = 11'(STEP) + 11'(pos_q >> 3);
    if (step > 11'(2 * STEP)) step = 11'(2 * STEP);
  end
`else
  assign step = 11'(STEP);
`endif

  // 11-bit sum so an object near the bottom never wraps back to the top.
  assign y_new = {1'b0, y_q[idx_q]} + step;

  // Next-state: FSM sequencing plus the shared per-slot update datapath.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    cd_d      = cd_q;
    lfsr_d    = lfsr_q;
    x_d       = x_q;
    y_d       = y_q;
    act_d     = act_q;
    pos_d     = pos_q;
    neg_d     = neg_q;
    catch_d   = 1'b0;
    miss_d    = 1'b0;
    // Cooldown ticks down once per sweep, ahead of slot 0's evaluation.
    cd_eff = (idx_q == '0 && cd_q != '0) ? cd_q - CdW'(1) : cd_q;

    unique case (state_q)
      StIdle: begin
        if (enable && tick) begin
          state_d = StSweep;
          idx_d   = '0;
        end
      end
      StSweep: begin
        if (!enable) begin
          // Abandon the partial sweep; slot state stays frozen.
          state_d   = StIdle;
          pending_d = 1'b0;
        end else begin
          cd_d = cd_eff;
          if (tick) pending_d = 1'b1;

          if (act_q[idx_q]) begin
            if (y_new >= 11'(Y_MAX)) begin
              act_d[idx_q] = 1'b0;
              miss_d       = 1'b1;
            end else if (y_new >= 11'(CATCH_Y) && x_q[idx_q] == farmer_x) begin
              act_d[idx_q] = 1'b0;
              y_d[idx_q]   = y_new[9:0];
              catch_d      = 1'b1;
              if (idx_q == '0) begin
                neg_d = (neg_q == 6'd63) ? neg_q : neg_q + 6'd1;
              end else begin
                pos_d = (pos_q == 6'd63) ? pos_q : pos_q + 6'd1;
              end
            end else begin
              y_d[idx_q] = y_new[9:0];
            end
          end else if (cd_eff == '0) begin
            // Reloading the cooldown limits spawning to one slot per sweep.
            x_d[idx_q]   = lfsr_q[2:0];
            y_d[idx_q]   = '0;
            act_d[idx_q] = 1'b1;
            cd_d         = CdW'(SPAWN_GAP);
            lfsr_d       = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
          end

          if (idx_q == LastIdx) begin
            if (pending_q || tick) begin
              idx_d     = '0;
              pending_d = 1'b0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; clear behaves exactly like reset and swallows a same-cycle tick.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      pending_q <= 1'b0;
      cd_q      <= '0;
      lfsr_q    <= LFSR_SEED;
      for (int i = 0; i < int'(N_OBJ); i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
      act_q     <= '0;
      pos_q     <= '0;
      neg_q     <= '0;
      catch_q   <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      cd_q      <= cd_d;
      lfsr_q    <= lfsr_d;
      x_q       <= x_d;
      y_q       <= y_d;
      act_q     <= act_d;
      pos_q     <= pos_d;
      neg_q     <= neg_d;
      catch_q   <= catch_d;
      miss_q    <= miss_d;
    end
  end

  // Pack per-slot registers onto the flat output buses.
  always_comb begin
    obj_x = '0;
    obj_y = '0;
    for (int i = 0; i < int'(N_OBJ); i++) begin
      obj_x[3*i +: 3]  = x_q[i];
      obj_y[10*i +: 10] = y_q[i];
    end
  end

  assign obj_active  = act_q;
  assign score_pos   = pos_q;
  assign score_neg   = neg_q;
  assign catch_pulse = catch_q;
  assign miss_pulse  = miss_q;
  assign busy        = (state_q == StSweep);

endmodule
